// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V core: opcode decode, step sequencing, mem_ready handshake with timeout.
// Define MULTICYCLE_CONTROL_RETIRE_CNT_EN to add the 32-bit retired-instruction counter output.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_source,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic [1:0]  ula_src_a,
    output logic [1:0]  ula_src_b,
    output logic [2:0]  ula_op,
    output logic        illegal_inst,
    output logic        bus_error,
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
    output logic [31:0] retired,
`endif
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LUI       = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] ula_src_a;
        logic [1:0] ula_src_b;
        logic [2:0] ula_op;
        logic       illegal_inst;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    // Moore control word of each state; ir_write and the FETCH pc_write are added on top.
    function automatic ctrl_t decode_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:     begin c.mem_read = 1'b1; c.ula_src_b = 2'b01; end
            S_DECODE:    c.ula_src_b = 2'b10;
            S_MEM_ADDR:  begin c.ula_src_a = 2'b01; c.ula_src_b = 2'b10; end
            S_MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
            S_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_EXEC_R:    begin c.ula_src_a = 2'b01; c.ula_op = 3'b010; end
            S_EXEC_I:    begin c.ula_src_a = 2'b01; c.ula_src_b = 2'b10; c.ula_op = 3'b011; end
            S_ALU_WB:    c.reg_write = 1'b1;
            S_BRANCH:    begin
                c.ula_src_a = 2'b01; c.ula_op = 3'b001;
                c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
            end
            S_JAL:       begin
                c.pc_write = 1'b1; c.pc_source = 2'b01;
                c.reg_write = 1'b1; c.mem_to_reg = 2'b10;
            end
            S_JALR:      begin
                c.ula_src_a = 2'b01; c.ula_src_b = 2'b10;
                c.pc_write = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 2'b10;
            end
            S_LUI:       begin c.ula_src_a = 2'b10; c.ula_src_b = 2'b10; c.ula_op = 3'b100; end
            default:     c.illegal_inst = 1'b1;
        endcase
        return c;
    endfunction

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
    ctrl_t                ctrl_q, ctrl_d;
    logic                 bus_err_q, bus_err_d;
    logic                 wait_state, timeout;
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
    logic [31:0]          retired_q, retired_d;
    logic                 retire_inc;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        state_d    = state_q;
        wait_state = (state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE});
        cnt_inc    = cnt_q + 1'b1;
        timeout    = TIMEOUT_EN && wait_state && !mem_ready &&
                     (cnt_inc == TIMEOUT_W'(TIMEOUT_CYCLES));

        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEM_WRITE: if (mem_ready || timeout) state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_ALU_WB;
            default:     state_d = S_FETCH;
        endcase

        // Counter only survives a cycle that stays in a wait state without completing or timing out.
        cnt_d     = (wait_state && !mem_ready && !timeout) ? cnt_inc : '0;
        bus_err_d = timeout;
        ctrl_d    = decode_ctrl(state_d);
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
        retire_inc = (state_d == S_FETCH) && !timeout &&
                     (state_q inside {S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_JAL, S_JALR});
        retired_d  = retire_inc ? retired_q + 32'd1 : retired_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            ctrl_q    <= decode_ctrl(S_FETCH);
            bus_err_q <= 1'b0;
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
            retired_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            bus_err_q <= bus_err_d;
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
            retired_q <= retired_d;
`endif
        end
    end

    // Registered control word tracks state_q; rst masks it so no enable leaks during reset.
    ctrl_t ctrl_o;
    logic  fetch_ack;
    assign ctrl_o    = rst ? '0 : ctrl_q;
    assign fetch_ack = !rst && (state_q == S_FETCH) && mem_ready;

    assign pc_write      = ctrl_o.pc_write | fetch_ack;
    assign pc_write_cond = ctrl_o.pc_write_cond;
    assign pc_source     = ctrl_o.pc_source;
    assign ir_write      = fetch_ack;
    assign i_or_d        = ctrl_o.i_or_d;
    assign mem_read      = ctrl_o.mem_read;
    assign mem_write     = ctrl_o.mem_write;
    assign mem_to_reg    = ctrl_o.mem_to_reg;
    assign reg_write     = ctrl_o.reg_write;
    assign ula_src_a     = ctrl_o.ula_src_a;
    assign ula_src_b     = ctrl_o.ula_src_b;
    assign ula_op        = ctrl_o.ula_op;
    assign illegal_inst  = ctrl_o.illegal_inst;
    assign bus_error     = bus_err_q & ~rst;
    assign state_dbg     = state_q;
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
    assign retired       = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed cases plus random instruction stream
// checked cycle by cycle against an instruction-level model of the control sequence.
module tb_multicycle_control;

    localparam int TO = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic        reg_write, illegal_inst, bus_error;
    logic [1:0]  pc_source, mem_to_reg, ula_src_a, ula_src_b;
    logic [2:0]  ula_op;
    logic [3:0]  state_dbg;
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    multicycle_control #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .ula_src_a(ula_src_a),
        .ula_src_b(ula_src_b), .ula_op(ula_op), .illegal_inst(illegal_inst),
        .bus_error(bus_error),
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
        .retired(retired),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    logic [19:0] act_outs;
    assign act_outs = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
                       mem_to_reg, reg_write, ula_src_a, ula_src_b, ula_op, illegal_inst, bus_error};

    int          checks   = 0;
    int          failures = 0;
    bit          pend_berr;
    int unsigned ret_model;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    // Expected output vector for a state number, straight from the control table.
    function automatic logic [19:0] exp_outs(input int st, input bit rdy, input bit berr);
        logic       pcw, pcwc, irw, iod, mr, mw, rw, ill;
        logic [1:0] pcs, m2r, sa, sb;
        logic [2:0] op;
        {pcw, pcwc, irw, iod, mr, mw, rw, ill} = '0;
        {pcs, m2r, sa, sb, op} = '0;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  sb = 2'b10;
            2:  begin sa = 2'b01; sb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 2'b01; end
            5:  begin mw = 1; iod = 1; end
            6:  begin sa = 2'b01; op = 3'b010; end
            7:  begin sa = 2'b01; sb = 2'b10; op = 3'b011; end
            8:  rw = 1;
            9:  begin sa = 2'b01; op = 3'b001; pcwc = 1; pcs = 2'b01; end
            10: begin pcw = 1; pcs = 2'b01; rw = 1; m2r = 2'b10; end
            11: begin sa = 2'b01; sb = 2'b10; pcw = 1; rw = 1; m2r = 2'b10; end
            12: begin sa = 2'b10; sb = 2'b10; op = 3'b100; end
            default: ill = 1;
        endcase
        return {pcw, pcwc, pcs, irw, iod, mr, mw, m2r, rw, sa, sb, op, ill, berr};
    endfunction

    // One clock cycle: entered just after a falling edge, leaves at the next falling edge.
    task automatic step(input int st, input bit rdy);
        logic [19:0] e;
        mem_ready = rdy;
        e = exp_outs(st, rdy, pend_berr);
        pend_berr = 1'b0;
        #1;
        check($sformatf("state(exp %0d)", st), 32'(state_dbg), 32'(st));
        check($sformatf("outs(state %0d)", st), 32'(act_outs), 32'(e));
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
        check("retired", retired, ret_model);
`endif
        @(negedge clk);
    endtask

    // A memory wait: w idle cycles then completion, or TO idle cycles then timeout.
    task automatic mem_phase(input int st, input int w, output bit done);
        if (w >= TO) begin
            for (int i = 0; i < TO; i++) step(st, 1'b0);
            pend_berr = 1'b1;
            done = 1'b0;
        end else begin
            for (int i = 0; i < w; i++) step(st, 1'b0);
            step(st, 1'b1);
            done = 1'b1;
        end
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 7) == 0) return TO + int'($urandom_range(0, 2));
        return int'($urandom_range(0, 3));
    endfunction

    function automatic int pick(input int fixed);
        return (fixed >= 0) ? fixed : rand_wait();
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] o;
        case ($urandom_range(0, 8))
            0: o = OP_R;
            1: o = OP_I;
            2: o = OP_LOAD;
            3: o = OP_STORE;
            4: o = OP_BRANCH;
            5: o = OP_JAL;
            6: o = OP_JALR;
            7: o = OP_LUI;
            default: begin
                do o = 7'($urandom); while (is_legal(o));
            end
        endcase
        return o;
    endfunction

    // Whole instruction: fetch (with retries on timeout), decode, then the class-specific steps.
    task automatic run_instr(input logic [6:0] op, input int fetch_w, input int mem_w);
        bit done;
        int tries;
        opcode = op;
        tries  = 0;
        do begin
            mem_phase(0, (tries == 0) ? pick(fetch_w) : ((tries < 8) ? rand_wait() : 0), done);
            tries++;
        end while (!done);
        step(1, rbit());
        case (op)
            OP_R:      begin step(6, rbit());  step(8, rbit()); ret_model++; end
            OP_I:      begin step(7, rbit());  step(8, rbit()); ret_model++; end
            OP_LUI:    begin step(12, rbit()); step(8, rbit()); ret_model++; end
            OP_LOAD: begin
                step(2, rbit());
                mem_phase(3, pick(mem_w), done);
                if (done) begin step(4, rbit()); ret_model++; end
            end
            OP_STORE: begin
                step(2, rbit());
                mem_phase(5, pick(mem_w), done);
                if (done) ret_model++;
            end
            OP_BRANCH: begin step(9, rbit());  ret_model++; end
            OP_JAL:    begin step(10, rbit()); ret_model++; end
            OP_JALR:   begin step(11, rbit()); ret_model++; end
            default:   step(13, rbit());
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        opcode    = OP_R;
        mem_ready = 1'b1;
        pend_berr = 1'b0;
        ret_model = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", 32'(act_outs), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
        check("reset_retired", retired, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_instr(OP_R, 0, 0);
        run_instr(OP_LOAD, 0, 2);
        run_instr(OP_LUI, 0, 0);
        run_instr(7'b1111111, 0, 0);
        run_instr(OP_STORE, 0, TO);
        run_instr(OP_STORE, 0, TO - 1);
        run_instr(OP_LOAD, 0, TO + 1);
        run_instr(OP_I, TO, 0);
        run_instr(OP_BRANCH, 1, 0);
        run_instr(OP_JAL, 0, 0);
        run_instr(OP_JALR, 0, 0);

        // Asynchronous reset in the middle of a store's memory wait.
        opcode = OP_STORE;
        step(0, 1'b1);
        step(1, 1'b0);
        step(2, 1'b1);
        mem_ready = 1'b0;
        #1;
        check("mw_before_rst", 32'(mem_write), 32'd1);
        check("state_before_rst", 32'(state_dbg), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("mw_async_rst", 32'(mem_write), 32'd0);
        check("state_async_rst", 32'(state_dbg), 32'd0);
        check("outs_async_rst", 32'(act_outs), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        pend_berr = 1'b0;
        ret_model = 0;

        for (int i = 0; i < 3; i++) run_instr(OP_R, 0, 0);
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
        #1;
        check("retired_after_3", retired, 32'd3);
        @(negedge clk);
        step(0, 1'b0);
        ret_model = 3;
        run_instr(OP_R, 0, 0);
`endif

        for (int i = 0; i < 300; i++) run_instr(rand_op(), -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
